// File: rtl/sd_arbiter_if.sv
// sd_arbiter_if: one master's view of the shared SD register/FIFO bus.
// Signals:
//   req        master -> arbiter  request, held for the whole transaction
//   gnt        arbiter -> master  registered grant
//   addr/we/wdata               register bus from the master
//   rdata      arbiter -> master  register read data, 0 when not granted
//   fifo_rd/fifo_we/fifo_wdata  SD FIFO strobes and write data
//   fifo_rdata arbiter -> master  SD read-FIFO data, 0 when not granted
// Modports: master (the requesting block), slave (the arbiter side).
interface sd_arbiter_if;
  logic       req;
  logic       gnt;
  logic [6:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       fifo_rd;
  logic [7:0] fifo_rdata;
  logic       fifo_we;
  logic [7:0] fifo_wdata;
  modport master (
    output req, addr, we, wdata, fifo_rd, fifo_we, fifo_wdata,
    input  gnt, rdata, fifo_rdata
  );
  modport slave (
    input  req, addr, we, wdata, fifo_rd, fifo_we, fifo_wdata,
    output gnt, rdata, fifo_rdata
  );
endinterface

// File: rtl/sd_arbiter.sv
// sd_arbiter: two-master round-robin arbiter in front of the shared sdc_controller.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0, m1                     sd_arbiter_if.slave, one per master
//   sd_addr/sd_we/sd_wdata     register bus to the controller
//   sd_fifo_rd/sd_fifo_we/sd_fifo_wdata  FIFO strobes to the controller
//   sd_rdata, sd_fifo_rdata    read data from the controller
//   owner                      current or most recent owner index
//   timeout_flag               sticky watchdog-revoke indicator
// Build option: define SD_ARB_TIMEOUT_EN to build the idle watchdog
// (TIMEOUT_CYCLES idle granted cycles revoke the owner and mask it until it
// drops its request); otherwise grants are held until released.
module sd_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic         clk,
  input  logic         rst_n,
  sd_arbiter_if.slave  m0,
  sd_arbiter_if.slave  m1,
  output logic [6:0]   sd_addr,
  output logic         sd_we,
  output logic [7:0]   sd_wdata,
  output logic         sd_fifo_rd,
  output logic         sd_fifo_we,
  output logic [7:0]   sd_fifo_wdata,
  input  logic [7:0]   sd_rdata,
  input  logic [7:0]   sd_fifo_rdata,
  output logic         owner,
  output logic         timeout_flag
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, HANDOVER} state_t;

  if (TIMEOUT_CYCLES < 16'd2) begin : g_timeout_check
    $error("sd_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       g0, g1;
  logic [1:0] elig;
  logic       revoke;
  state_t     pick;

  assign g0 = state_q == GNT0;
  assign g1 = state_q == GNT1;

  // Controller side: only the owner's signals get through; everything is 0
  // with no grant, which also makes HANDOVER a dead cycle.
  assign sd_addr       = g0 ? m0.addr       : g1 ? m1.addr       : 7'h00;
  assign sd_we         = g0 ? m0.we         : g1 ? m1.we         : 1'b0;
  assign sd_wdata      = g0 ? m0.wdata      : g1 ? m1.wdata      : 8'h00;
  assign sd_fifo_rd    = g0 ? m0.fifo_rd    : g1 ? m1.fifo_rd    : 1'b0;
  assign sd_fifo_we    = g0 ? m0.fifo_we    : g1 ? m1.fifo_we    : 1'b0;
  assign sd_fifo_wdata = g0 ? m0.fifo_wdata : g1 ? m1.fifo_wdata : 8'h00;

  assign m0.gnt        = g0;
  assign m1.gnt        = g1;
  assign m0.rdata      = g0 ? sd_rdata      : 8'h00;
  assign m1.rdata      = g1 ? sd_rdata      : 8'h00;
  assign m0.fifo_rdata = g0 ? sd_fifo_rdata : 8'h00;
  assign m1.fifo_rdata = g1 ? sd_fifo_rdata : 8'h00;

  assign owner = owner_q;

  // Round-robin: on a tie the master that did not own the bus last wins.
  assign pick = elig == 2'b11 ? (owner_q ? GNT0 : GNT1) :
                elig[0]       ? GNT0 :
                elig[1]       ? GNT1 : IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      GNT0:    state_d = (!m0.req || revoke) ? HANDOVER : GNT0;
      GNT1:    state_d = (!m1.req || revoke) ? HANDOVER : GNT1;
      default: state_d = pick;
    endcase
    owner_d = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  mask_q, mask_d;
  logic        flag_q, flag_d;
  logic        idle_gnt;

  // Any strobe reaching the controller counts as owner activity.
  assign idle_gnt = (g0 || g1) && !sd_we && !sd_fifo_rd && !sd_fifo_we;
  // A release in the same cycle is an ordinary handover, not a revoke.
  assign revoke   = idle_gnt && (g0 ? m0.req : m1.req) &&
                    cnt_q == TIMEOUT_CYCLES - 16'd1;
  assign elig         = {m1.req, m0.req} & ~mask_q;
  assign timeout_flag = flag_q;

  always_comb begin
    cnt_d  = (state_d != state_q || !idle_gnt) ? 16'd0 : cnt_q + 16'd1;
    // A revoked master stays masked until it is seen with req low.
    mask_d = ({m1.req, m0.req} & mask_q) | (revoke ? {g1, g0} : 2'b00);
    flag_d = flag_q | revoke;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      mask_q <= 2'b00;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      flag_q <= flag_d;
    end
  end
`else
  assign revoke       = 1'b0;
  assign elig         = {m1.req, m0.req};
  assign timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter: table-driven and directed checks for sd_arbiter.
module tb_sd_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sd_addr;
  logic       sd_we, sd_fifo_rd, sd_fifo_we, owner, timeout_flag;
  logic [7:0] sd_wdata, sd_fifo_wdata;
  logic [7:0] sd_rdata = 8'h77;
  logic [7:0] sd_fifo_rdata = 8'h99;
  int checks = 0;
  int errors = 0;

  sd_arbiter_if m0_if ();
  sd_arbiter_if m1_if ();

  sd_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .sd_addr(sd_addr), .sd_we(sd_we), .sd_wdata(sd_wdata),
    .sd_fifo_rd(sd_fifo_rd), .sd_fifo_we(sd_fifo_we), .sd_fifo_wdata(sd_fifo_wdata),
    .sd_rdata(sd_rdata), .sd_fifo_rdata(sd_fifo_rdata),
    .owner(owner), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Inputs: r0 r1 we0 fr0 fw0 we1 fr1 fw1 ; expected: g0 g1 own swe sfr sfw
  typedef struct packed {
    logic r0, r1, we0, fr0, fw0, we1, fr1, fw1;
    logic g0, g1, own, swe, sfr, sfw;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    m0_if.req = v.r0; m0_if.we = v.we0; m0_if.fifo_rd = v.fr0; m0_if.fifo_we = v.fw0;
    m1_if.req = v.r1; m1_if.we = v.we1; m1_if.fifo_rd = v.fr1; m1_if.fifo_we = v.fw1;
  endtask

  task automatic do_reset();
    drive('0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    m0_if.addr = 7'h04; m0_if.wdata = 8'hA5; m0_if.fifo_wdata = 8'h3C;
    m1_if.addr = 7'h11; m1_if.wdata = 8'h5A; m1_if.fifo_wdata = 8'hC3;
    drive('0);
    tbl.push_back(14'b00000000_001000);
    tbl.push_back(14'b10000000_100000);
    tbl.push_back(14'b10100000_100100);
    tbl.push_back(14'b11000101_100000);
    tbl.push_back(14'b01000100_000000);
    tbl.push_back(14'b01000000_011000);
    tbl.push_back(14'b01011010_011010);
    tbl.push_back(14'b11000000_011000);
    tbl.push_back(14'b10000000_001000);
    tbl.push_back(14'b10000000_100000);
    tbl.push_back(14'b00000000_000000);
    tbl.push_back(14'b00000000_000000);
    tbl.push_back(14'b11000000_011000);
    tbl.push_back(14'b10000000_001000);
    tbl.push_back(14'b10000000_100000);
    tbl.push_back(14'b00000000_000000);
    tbl.push_back(14'b11000000_011000);
    tbl.push_back(14'b00000000_001000);
    tbl.push_back(14'b00000000_001000);
    tbl.push_back(14'b11000000_100000);
    tbl.push_back(14'b10010000_100010);
    tbl.push_back(14'b00000000_000000);

    step();
    step();
    chk("reset gnt", {m0_if.gnt, m1_if.gnt}, 2'b00);
    chk("reset owner", owner, 1'b1);
    chk("reset flag", timeout_flag, 1'b0);
    chk("reset sd", {sd_addr, sd_we, sd_wdata, sd_fifo_rd, sd_fifo_we, sd_fifo_wdata}, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v);
      step();
      chk($sformatf("row%0d gnt", i), {m0_if.gnt, m1_if.gnt}, {v.g0, v.g1});
      chk($sformatf("row%0d owner", i), owner, v.own);
      chk($sformatf("row%0d strobes", i), {sd_we, sd_fifo_rd, sd_fifo_we}, {v.swe, v.sfr, v.sfw});
      chk($sformatf("row%0d bus", i), {sd_addr, sd_wdata, sd_fifo_wdata},
          v.g0 ? {7'h04, 8'hA5, 8'h3C} : v.g1 ? {7'h11, 8'h5A, 8'hC3} : 23'h0);
      chk($sformatf("row%0d m0 rd", i), {m0_if.rdata, m0_if.fifo_rdata}, v.g0 ? 16'h7799 : 16'h0);
      chk($sformatf("row%0d m1 rd", i), {m1_if.rdata, m1_if.fifo_rdata}, v.g1 ? 16'h7799 : 16'h0);
    end

    // Tie straight out of reset, handover to m1, then a repeated tie.
    do_reset();
    drive(14'b11000000_000000);
    step();
    chk("tie first gnt", {m0_if.gnt, m1_if.gnt}, 2'b10);
    m0_if.req = 1'b0;
    step();
    chk("tie handover", {m0_if.gnt, m1_if.gnt}, 2'b00);
    step();
    chk("tie m1 gnt", {m0_if.gnt, m1_if.gnt, owner}, 3'b011);
    m1_if.req = 1'b0;
    step();
    chk("tie m1 release", {m0_if.gnt, m1_if.gnt}, 2'b00);
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    step();
    chk("tie repeat", {m0_if.gnt, m1_if.gnt, owner}, 3'b100);

    // Asynchronous reset in the middle of an m1 FIFO read.
    do_reset();
    drive(14'b01000010_000000);
    step();
    chk("pre-reset fifo_rd", {m1_if.gnt, sd_fifo_rd}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset gnt", {m0_if.gnt, m1_if.gnt}, 2'b00);
    chk("async reset sd", {sd_addr, sd_we, sd_wdata, sd_fifo_rd, sd_fifo_we, sd_fifo_wdata}, 0);
    chk("async reset rd", {m1_if.rdata, m1_if.fifo_rdata}, 16'h0);
    chk("async reset owner", owner, 1'b1);
    drive('0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post-reset idle", {m0_if.gnt, m1_if.gnt, owner}, 3'b001);
    m0_if.req = 1'b1;
    step();
    chk("post-reset grant", {m0_if.gnt, m1_if.gnt}, 2'b10);

    // Idle owner: revoked after 16 cycles with the watchdog, held otherwise.
    do_reset();
    m1_if.req = 1'b1;
    step();
    begin
      int hi = 0;
`ifdef SD_ARB_TIMEOUT_EN
      repeat (16) begin
        if (m1_if.gnt) hi++;
        step();
      end
      chk("timeout held cycles", hi, 16);
      chk("timeout revoke", m1_if.gnt, 1'b0);
      chk("timeout flag", timeout_flag, 1'b1);
      repeat (3) step();
      chk("timeout masked", m1_if.gnt, 1'b0);
      m1_if.req = 1'b0;
      step();
      m1_if.req = 1'b1;
      step();
      chk("timeout regrant", m1_if.gnt, 1'b1);
      chk("timeout flag sticky", timeout_flag, 1'b1);
`else
      repeat (40) begin
        if (m1_if.gnt) hi++;
        step();
      end
      chk("hold no watchdog", hi, 40);
      chk("flag tied low", timeout_flag, 1'b0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
